// File: rtl/circuit.sv
// Registered carry-lookahead adder.
// Two lookahead levels: 4-bit groups compute their internal carries
// directly from the per-bit generate/propagate terms. A second level
// computes every group carry-in from the group generate/propagate
// terms, so no carry ripples from one group to the next.
// The sum and carry-out are captured in one output register.
module circuit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP:0]    gc;

    assign g = A & B;
    assign p = A ^ B;

    // First level: carries inside each 4-bit group, fully expanded from
    // the group carry-in, plus the group generate/propagate terms.
    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        localparam int B0 = 4 * j;
        assign c[B0]     = gc[j];
        assign c[B0 + 1] = g[B0] | (p[B0] & gc[j]);
        assign c[B0 + 2] = g[B0 + 1] | (p[B0 + 1] & g[B0])
                         | (p[B0 + 1] & p[B0] & gc[j]);
        assign c[B0 + 3] = g[B0 + 2] | (p[B0 + 2] & g[B0 + 1])
                         | (p[B0 + 2] & p[B0 + 1] & g[B0])
                         | (p[B0 + 2] & p[B0 + 1] & p[B0] & gc[j]);
        assign gg[j] = g[B0 + 3] | (p[B0 + 3] & g[B0 + 2])
                     | (p[B0 + 3] & p[B0 + 2] & g[B0 + 1])
                     | (p[B0 + 3] & p[B0 + 2] & p[B0 + 1] & g[B0]);
        assign gp[j] = &p[B0 +: 4];
    end

    // Second level: each group carry is the OR over every lower group that
    // generates and whose carry is propagated by all groups in between.
    // The carry-in to group 0 is tied to zero.
    always_comb begin
        logic term;
        gc = '0;
        term = 1'b0;
        for (int j = 1; j <= NGRP; j++) begin
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                gc[j] = gc[j] | term;
            end
        end
    end

    assign sum = p ^ c;

    // Output register: reloads every cycle and is cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= sum;
            Cout <= gc[NGRP];
        end
    end

endmodule

// File: tb/tb_circuit.sv
// Bench for the registered CLA adder (WIDTH=4). Expected results come from
// plain integer addition of the operands applied before each edge.
module tb_circuit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       cout;

    int passed = 0;
    int total  = 0;

    circuit #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .B    (b),
        .S    (s),
        .Cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_add(input int x, input int y);
        int r;
        r = (x + y) % 32;
        return r[4:0];
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed {Cout,S}=%b expected %b", tag, obs, expv);
    endtask

    // Drive operands mid-cycle, then check one edge later.
    task automatic apply(input string tag, input int x, input int y);
        @(negedge clk);
        a = x[3:0];
        b = y[3:0];
        @(posedge clk);
        #1;
        check(tag, {cout, s}, ref_add(x, y));
    endtask

    initial begin
        int x;
        int y;

        // Reset held with nonzero operands and a running clock.
        rst_n = 1'b0;
        a = 4'b1111;
        b = 4'b1001;
        #1;
        check("reset_t0", {cout, s}, 5'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", {cout, s}, 5'b0);
        end

        // Release: first capture on first edge with rst_n high.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture_15p9", {cout, s}, 5'b11000);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("stable_15p9", {cout, s}, 5'b11000);
        end

        // Full propagate chain and carry through every bit.
        apply("prop_10p5", 10, 5);
        apply("prop_15p1", 15, 1);

        // Boundaries.
        apply("bnd_0p0", 0, 0);
        apply("bnd_15p15", 15, 15);
        apply("bnd_8p8", 8, 8);

        // Back-to-back with a glitch on A between edges.
        apply("b2b_3p4", 3, 4);
        #1;
        a = 4'b1111;
        #2;
        check("glitch_hold", {cout, s}, 5'b00111);
        apply("b2b_7p9", 7, 9);
        apply("b2b_12p5", 12, 5);

        // Asynchronous reset between edges clears at once.
        apply("pre_reset_9p9", 9, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {cout, s}, 5'b0);
        @(posedge clk);
        #1;
        check("reset_over_edge", {cout, s}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("resume_6p13", 6, 13);

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                apply("exhaustive", i, j);
            end
        end

        // Random pairs, one per cycle.
        for (int n = 0; n < 64; n++) begin
            x = int'($urandom_range(15, 0));
            y = int'($urandom_range(15, 0));
            apply("random", x, y);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
